ascon_perm_ctrl: RTL and testbench
==================================

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

Interface
REQ-001 SHALL have parameter ROUND_CYCLES, default 1, clock cycles per permutation round; legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port start_i  input  1  permutation request; accepted only when ready_o=1.
REQ-005 SHALL have port rounds_i  input  5  requested round count; legal values 6, 8, 12.
REQ-006 SHALL have port ack_i  input  1  consumer acknowledge of done_o.
REQ-007 SHALL have port ready_o  output  1  idle; a request can be accepted.
REQ-008 SHALL have port busy_o  output  1  high in LOAD, RUN and DONE.
REQ-009 SHALL have port state_load_o  output  1  one-cycle strobe to load the 320-bit state register.
REQ-010 SHALL have port round_en_o  output  1  strobe to commit one round result.
REQ-011 SHALL have port ctr_o  output  5  current round index for the round-constant stage.
REQ-012 SHALL have port rounds_o  output  5  latched round count for the round-constant stage.
REQ-013 SHALL have port done_o  output  1  permutation complete; held until acknowledged.
REQ-014 SHALL have port err_o  output  1  one-cycle pulse on an illegal rounds_i.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-016 In IDLE, ready_o=1; start_i=1 with legal rounds_i latches rounds_o and moves to LOAD.
REQ-017 In IDLE, start_i=1 with an illegal rounds_i (anything except 6, 8 or 12) pulses err_o for the next cycle; FSM stays IDLE and rounds_o is unchanged.
REQ-018 In LOAD, state_load_o=1 for exactly one cycle, ctr_o=0, sub-counter=0; next state RUN.
REQ-019 In RUN, the sub-counter counts 0..ROUND_CYCLES-1; round_en_o=1 only when sub-counter=ROUND_CYCLES-1.
REQ-020 On round_en_o with ctr_o<rounds_o-1: ctr_o increments and the sub-counter wraps to 0.
REQ-021 On round_en_o with ctr_o=rounds_o-1: next state is DONE and ctr_o clears to 0.
REQ-022 ctr_o SHALL hold constant across all sub-cycles of one round; it never exceeds rounds_o-1.
REQ-023 Latency: if start is accepted at cycle T, done_o first asserts at T+2+rounds_o*ROUND_CYCLES.
REQ-024 In DONE, done_o=1 until ack_i=1; then IDLE on the next cycle, with ready_o=1 in that cycle.
REQ-025 start_i is ignored outside IDLE, including a cycle where start_i and ack_i are both high in DONE.
REQ-026 round_en_o and state_load_o SHALL never be high in the same cycle; both are 0 outside LOAD/RUN.
REQ-027 rounds_o SHALL hold its latched value until the next accepted start.

Reset
REQ-028 With rst_n=0 at a clock edge: FSM=IDLE, ready_o=1, busy_o=0, state_load_o=0, round_en_o=0, ctr_o=0, rounds_o=0, done_o=0, err_o=0, sub-counter=0.
REQ-029 Reset SHALL take effect mid-operation in any state; no done_o is produced for an interrupted permutation.

Configuration
REQ-030 With macro ASCON_PERM_CTRL_ABORT_EN defined, an extra port abort_i (input, 1 bit) SHALL exist.
REQ-031 With the macro defined, abort_i=1 in LOAD or RUN SHALL force IDLE on the next cycle with ctr_o=0, no round_en_o in that cycle, and no done_o.
REQ-032 With the macro defined, abort_i SHALL be ignored in IDLE and DONE.
REQ-033 Without the macro, abort_i SHALL NOT exist and REQ-031/REQ-032 do not apply.

Verification
REQ-034 ROUND_CYCLES=1, start at T with rounds_i=12 -> state_load_o at T+1; round_en_o at T+2..T+13 with ctr_o 0..11; done_o at T+14.
REQ-035 ROUND_CYCLES=2, rounds_i=6 -> 6 round_en_o pulses on alternate cycles; done_o at T+14; ctr_o stable within each pair.
REQ-036 rounds_i=7 with start_i in IDLE -> err_o=1 for one cycle; ready_o stays 1; rounds_o unchanged; no state_load_o.
REQ-037 done_o held for 5 cycles with ack_i=0, then ack_i=1 and start_i=1 together -> IDLE next cycle with no LOAD; a start_i one cycle later is accepted.
REQ-038 rst_n=0 during RUN at ctr_o=4 (rounds 8) -> all outputs at reset values the next cycle; no done_o follows.
REQ-039 ASCON_PERM_CTRL_ABORT_EN defined, abort_i=1 at ctr_o=3 -> IDLE next cycle, ctr_o=0, done_o never asserts.

Source files
------------

// File: rtl/ascon_perm_ctrl_if.sv
// rtl/ascon_perm_ctrl_if.sv - request/status bundle for the Ascon permutation controller
interface ascon_perm_ctrl_if;
    logic       start_i;
    logic [4:0] rounds_i;
    logic       ack_i;
    logic       ready_o;
    logic       busy_o;
    logic       state_load_o;
    logic       round_en_o;
    logic [4:0] ctr_o;
    logic [4:0] rounds_o;
    logic       done_o;
    logic       err_o;

    modport master (
        output start_i, rounds_i, ack_i,
        input  ready_o, busy_o, state_load_o, round_en_o, ctr_o, rounds_o, done_o, err_o
    );

    modport slave (
        input  start_i, rounds_i, ack_i,
        output ready_o, busy_o, state_load_o, round_en_o, ctr_o, rounds_o, done_o, err_o
    );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - Ascon permutation round sequencer; ASCON_PERM_CTRL_ABORT_EN adds abort_i
module ascon_perm_ctrl #(
    parameter int ROUND_CYCLES = 1
) (
    input logic clk,
    input logic rst_n,
`ifdef ASCON_PERM_CTRL_ABORT_EN
    input logic abort_i,
`endif
    ascon_perm_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [1:0] SUB_LAST = 2'(ROUND_CYCLES - 1);

    state_t     state;
    logic [1:0] sub;
    logic       abort;
    logic       legal;

`ifdef ASCON_PERM_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign legal = (bus.rounds_i == 5'd6) || (bus.rounds_i == 5'd8) || (bus.rounds_i == 5'd12);

    // Outputs are registered: each branch sets the values the next state presents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            sub              <= 2'd0;
            bus.ready_o      <= 1'b1;
            bus.busy_o       <= 1'b0;
            bus.state_load_o <= 1'b0;
            bus.round_en_o   <= 1'b0;
            bus.ctr_o        <= 5'd0;
            bus.rounds_o     <= 5'd0;
            bus.done_o       <= 1'b0;
            bus.err_o        <= 1'b0;
        end else begin
            bus.err_o        <= 1'b0;
            bus.state_load_o <= 1'b0;
            bus.round_en_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (legal) begin
                            state            <= LOAD;
                            bus.rounds_o     <= bus.rounds_i;
                            bus.ready_o      <= 1'b0;
                            bus.busy_o       <= 1'b1;
                            bus.state_load_o <= 1'b1;
                            bus.ctr_o        <= 5'd0;
                            sub              <= 2'd0;
                        end else begin
                            bus.err_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state          <= RUN;
                    sub            <= 2'd0;
                    bus.ctr_o      <= 5'd0;
                    bus.round_en_o <= (SUB_LAST == 2'd0);
                end
                RUN: begin
                    if (sub == SUB_LAST) begin
                        sub <= 2'd0;
                        if (bus.ctr_o == bus.rounds_o - 5'd1) begin
                            state      <= DONE;
                            bus.ctr_o  <= 5'd0;
                            bus.done_o <= 1'b1;
                        end else begin
                            bus.ctr_o      <= bus.ctr_o + 5'd1;
                            bus.round_en_o <= (SUB_LAST == 2'd0);
                        end
                    end else begin
                        sub            <= sub + 2'd1;
                        bus.round_en_o <= (sub + 2'd1 == SUB_LAST);
                    end
                end
                DONE: begin
                    if (bus.ack_i) begin
                        state       <= IDLE;
                        bus.done_o  <= 1'b0;
                        bus.busy_o  <= 1'b0;
                        bus.ready_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Abort overrides whatever LOAD/RUN scheduled, including a pending DONE.
            if (abort && (state == LOAD || state == RUN)) begin
                state            <= IDLE;
                sub              <= 2'd0;
                bus.ctr_o        <= 5'd0;
                bus.round_en_o   <= 1'b0;
                bus.state_load_o <= 1'b0;
                bus.done_o       <= 1'b0;
                bus.busy_o       <= 1'b0;
                bus.ready_o      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - directed self-checking bench for ascon_perm_ctrl
module tb_ascon_perm_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    always #5 clk = ~clk;

    ascon_perm_ctrl_if i1();
    ascon_perm_ctrl_if i2();

`ifdef ASCON_PERM_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif

    ascon_perm_ctrl #(.ROUND_CYCLES(1)) dut1 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ASCON_PERM_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .bus(i1)
    );

    ascon_perm_ctrl #(.ROUND_CYCLES(2)) dut2 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ASCON_PERM_CTRL_ABORT_EN
        .abort_i(1'b0),
`endif
        .bus(i2)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i1.start_i = 1'b0; i1.rounds_i = 5'd0; i1.ack_i = 1'b0;
        i2.start_i = 1'b0; i2.rounds_i = 5'd0; i2.ack_i = 1'b0;
        step(); step();
        total++; if (i1.ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", i1.ready_o); else pass_cnt++;
        total++; if (i1.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", i1.busy_o); else pass_cnt++;
        total++; if (i1.state_load_o !== 1'b0 || i1.round_en_o !== 1'b0)
            $display("FAIL reset_strobes got load=%b ren=%b want 0 0", i1.state_load_o, i1.round_en_o); else pass_cnt++;
        total++; if (i1.ctr_o !== 5'd0 || i1.rounds_o !== 5'd0)
            $display("FAIL reset_ctr got ctr=%0d rounds=%0d want 0 0", i1.ctr_o, i1.rounds_o); else pass_cnt++;
        total++; if (i1.done_o !== 1'b0 || i1.err_o !== 1'b0)
            $display("FAIL reset_done_err got done=%b err=%b want 0 0", i1.done_o, i1.err_o); else pass_cnt++;
        total++; if (i2.ready_o !== 1'b1 || i2.busy_o !== 1'b0)
            $display("FAIL reset_rc2 got ready=%b busy=%b want 1 0", i2.ready_o, i2.busy_o); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rounds12();
        i1.rounds_i = 5'd12; i1.start_i = 1'b1;
        step();
        i1.start_i = 1'b0;
        total++; if (i1.state_load_o !== 1'b1 || i1.round_en_o !== 1'b0)
            $display("FAIL r12_load got load=%b ren=%b want 1 0", i1.state_load_o, i1.round_en_o); else pass_cnt++;
        total++; if (i1.ready_o !== 1'b0 || i1.busy_o !== 1'b1 || i1.rounds_o !== 5'd12)
            $display("FAIL r12_status got ready=%b busy=%b rounds=%0d want 0 1 12", i1.ready_o, i1.busy_o, i1.rounds_o); else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            step();
            total++;
            if (i1.round_en_o !== 1'b1 || i1.ctr_o !== 5'(k) || i1.state_load_o !== 1'b0 || i1.done_o !== 1'b0)
                $display("FAIL r12_round%0d got ren=%b ctr=%0d load=%b done=%b want 1 %0d 0 0",
                         k, i1.round_en_o, i1.ctr_o, i1.state_load_o, i1.done_o, k);
            else pass_cnt++;
        end
        step();
        total++; if (i1.done_o !== 1'b1 || i1.round_en_o !== 1'b0 || i1.ctr_o !== 5'd0 || i1.busy_o !== 1'b1)
            $display("FAIL r12_done got done=%b ren=%b ctr=%0d busy=%b want 1 0 0 1", i1.done_o, i1.round_en_o, i1.ctr_o, i1.busy_o); else pass_cnt++;
        i1.ack_i = 1'b1;
        step();
        i1.ack_i = 1'b0;
        total++; if (i1.done_o !== 1'b0 || i1.ready_o !== 1'b1 || i1.busy_o !== 1'b0)
            $display("FAIL r12_ack got done=%b ready=%b busy=%b want 0 1 0", i1.done_o, i1.ready_o, i1.busy_o); else pass_cnt++;
    endtask

    task automatic test_illegal();
        i1.rounds_i = 5'd7; i1.start_i = 1'b1;
        step();
        i1.start_i = 1'b0;
        total++; if (i1.err_o !== 1'b1 || i1.ready_o !== 1'b1 || i1.state_load_o !== 1'b0)
            $display("FAIL illegal7 got err=%b ready=%b load=%b want 1 1 0", i1.err_o, i1.ready_o, i1.state_load_o); else pass_cnt++;
        total++; if (i1.rounds_o !== 5'd12)
            $display("FAIL illegal7_rounds got %0d want 12", i1.rounds_o); else pass_cnt++;
        step();
        total++; if (i1.err_o !== 1'b0 || i1.ready_o !== 1'b1 || i1.state_load_o !== 1'b0 || i1.busy_o !== 1'b0)
            $display("FAIL illegal7_after got err=%b ready=%b load=%b busy=%b want 0 1 0 0", i1.err_o, i1.ready_o, i1.state_load_o, i1.busy_o); else pass_cnt++;
        i1.rounds_i = 5'd0; i1.start_i = 1'b1;
        step();
        i1.start_i = 1'b0;
        total++; if (i1.err_o !== 1'b1 || i1.state_load_o !== 1'b0 || i1.rounds_o !== 5'd12)
            $display("FAIL illegal0 got err=%b load=%b rounds=%0d want 1 0 12", i1.err_o, i1.state_load_o, i1.rounds_o); else pass_cnt++;
        step();
    endtask

    task automatic test_done_hold();
        int lat;
        bit held;
        i1.rounds_i = 5'd6; i1.start_i = 1'b1;
        step();
        i1.start_i = 1'b0;
        lat = 1;
        while (i1.done_o !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
        total++; if (lat !== 8) $display("FAIL r6_latency got %0d want 8", lat); else pass_cnt++;
        held = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (i1.done_o !== 1'b1) held = 1'b0;
        end
        total++; if (held !== 1'b1) $display("FAIL done_hold got dropped want held 5 cycles"); else pass_cnt++;
        i1.ack_i = 1'b1; i1.start_i = 1'b1; i1.rounds_i = 5'd8;
        step();
        i1.ack_i = 1'b0;
        total++; if (i1.ready_o !== 1'b1 || i1.state_load_o !== 1'b0 || i1.done_o !== 1'b0 || i1.busy_o !== 1'b0)
            $display("FAIL ack_start got ready=%b load=%b done=%b busy=%b want 1 0 0 0", i1.ready_o, i1.state_load_o, i1.done_o, i1.busy_o); else pass_cnt++;
        step();
        i1.start_i = 1'b0;
        total++; if (i1.state_load_o !== 1'b1 || i1.rounds_o !== 5'd8)
            $display("FAIL restart got load=%b rounds=%0d want 1 8", i1.state_load_o, i1.rounds_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        repeat (5) step();
        total++; if (i1.ctr_o !== 5'd4 || i1.round_en_o !== 1'b1)
            $display("FAIL mid_ctr got ctr=%0d ren=%b want 4 1", i1.ctr_o, i1.round_en_o); else pass_cnt++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (i1.ready_o !== 1'b1 || i1.busy_o !== 1'b0 || i1.state_load_o !== 1'b0 || i1.round_en_o !== 1'b0)
            $display("FAIL mid_reset_ctl got ready=%b busy=%b load=%b ren=%b want 1 0 0 0", i1.ready_o, i1.busy_o, i1.state_load_o, i1.round_en_o); else pass_cnt++;
        total++; if (i1.ctr_o !== 5'd0 || i1.rounds_o !== 5'd0 || i1.done_o !== 1'b0 || i1.err_o !== 1'b0)
            $display("FAIL mid_reset_data got ctr=%0d rounds=%0d done=%b err=%b want 0 0 0 0", i1.ctr_o, i1.rounds_o, i1.done_o, i1.err_o); else pass_cnt++;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (i1.done_o !== 1'b0 || i1.round_en_o !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL mid_reset_quiet got activity want none"); else pass_cnt++;
    endtask

    task automatic test_rc2();
        i2.rounds_i = 5'd6; i2.start_i = 1'b1;
        step();
        i2.start_i = 1'b0;
        total++; if (i2.state_load_o !== 1'b1 || i2.rounds_o !== 5'd6)
            $display("FAIL rc2_load got load=%b rounds=%0d want 1 6", i2.state_load_o, i2.rounds_o); else pass_cnt++;
        for (int o = 2; o <= 13; o++) begin
            step();
            total++;
            if (i2.round_en_o !== 1'((o % 2) == 1) || i2.ctr_o !== 5'((o - 2) / 2) || i2.done_o !== 1'b0)
                $display("FAIL rc2_cycle%0d got ren=%b ctr=%0d done=%b want %0d %0d 0",
                         o, i2.round_en_o, i2.ctr_o, i2.done_o, (o % 2), (o - 2) / 2);
            else pass_cnt++;
        end
        step();
        total++; if (i2.done_o !== 1'b1 || i2.round_en_o !== 1'b0)
            $display("FAIL rc2_done got done=%b ren=%b want 1 0", i2.done_o, i2.round_en_o); else pass_cnt++;
        i2.ack_i = 1'b1;
        step();
        i2.ack_i = 1'b0;
        total++; if (i2.ready_o !== 1'b1 || i2.done_o !== 1'b0)
            $display("FAIL rc2_ack got ready=%b done=%b want 1 0", i2.ready_o, i2.done_o); else pass_cnt++;
    endtask

`ifdef ASCON_PERM_CTRL_ABORT_EN
    task automatic test_abort();
        bit seen;
        i1.rounds_i = 5'd12; i1.start_i = 1'b1;
        step();
        i1.start_i = 1'b0;
        repeat (4) step();
        total++; if (i1.ctr_o !== 5'd3) $display("FAIL abort_pre got ctr=%0d want 3", i1.ctr_o); else pass_cnt++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (i1.ready_o !== 1'b1 || i1.ctr_o !== 5'd0 || i1.round_en_o !== 1'b0 || i1.busy_o !== 1'b0)
            $display("FAIL abort_idle got ready=%b ctr=%0d ren=%b busy=%b want 1 0 0 0", i1.ready_o, i1.ctr_o, i1.round_en_o, i1.busy_o); else pass_cnt++;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (i1.done_o !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL abort_no_done got done want none"); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_rounds12();
        test_illegal();
        test_done_hold();
        test_reset_mid_run();
        test_rc2();
`ifdef ASCON_PERM_CTRL_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
